// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length-prefixed byte stream into instruction memory
// and holds the core in reset until the whole image has been written.
//
// Stream: LEN[7:0], LEN[15:8], then 4*LEN bytes, each 32-bit word LSB first.
//
// Ports:
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   rx_valid      byte source presents rx_data
//   rx_data       stream byte
//   rx_ready      loader accepts a byte this cycle
//   imem_we       one-cycle write strobe per assembled word
//   imem_addr     word address of the write (holds last value otherwise)
//   imem_wdata    word being written (holds last value otherwise)
//   core_rst      core reset, released once the image is complete
//   load_done     image fully written (sticky until rst)
//   load_err      header length exceeds memory capacity (sticky until rst)
//   words_loaded  number of words written so far
module imem_boot_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned CAP   = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [15:0]         len_q, len_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         word_q, word_d;      // lower three bytes of the word in progress
  logic [CNT_W-1:0]    cnt_q, cnt_d;        // word index == words written so far
  logic                rx_ready_q, rx_ready_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                core_rst_q, core_rst_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;

  logic                xfer_c;
  logic [15:0]         len_new_c;
  logic [CNT_W-1:0]    cnt_inc_c;

  // rx_ready is a registered decode of the state, so it is also the transfer qualifier
  assign xfer_c = rx_valid & rx_ready_q;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LEN0;
      len_lo_q     <= '0;
      len_q        <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      cnt_q        <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_q   <= core_rst_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    cnt_d        = cnt_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    len_new_c    = {rx_data, len_lo_q};
    cnt_inc_c    = cnt_q + CNT_W'(1);

    case (state_q)
      S_LEN0: begin
        if (xfer_c) begin
          len_lo_d = rx_data;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer_c) begin
          len_d      = len_new_c;
          byte_idx_d = 2'd0;
          cnt_d      = '0;
          if (len_new_c == 16'd0) begin
            state_d = S_DONE;
          end else if (32'(len_new_c) > CAP) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer_c) begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = rx_data;
            2'd1: word_d[15:8]  = rx_data;
            2'd2: word_d[23:16] = rx_data;
            default: begin
              // Fourth byte goes straight into the write register, no extra cycle
              imem_addr_d  = cnt_q[ADDR_W-1:0];
              imem_wdata_d = {rx_data, word_q};
              state_d      = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_inc_c;
        state_d = (17'(cnt_inc_c) == 17'(len_q)) ? S_DONE : S_DATA;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_LEN0;
      end
    endcase

    // Outputs are registered decodes of the next state
    rx_ready_d  = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
    imem_we_d   = (state_d == S_WRITE);
    core_rst_d  = (state_d != S_DONE);
    load_done_d = (state_d == S_DONE);
    load_err_d  = (state_d == S_ERR);
  end

  assign rx_ready     = rx_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign core_rst     = core_rst_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign words_loaded = cnt_q;

endmodule
